// File: rtl/axil_if.sv
// AXI-Lite bus bundle for a single slave port: AW, W, B, AR and R channels.
// Each channel moves one beat on the clock edge where its valid and ready are both high.
interface axil_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] s_axil_awaddr;
   logic [2:0]            s_axil_awprot;
   logic                  s_axil_awvalid;
   logic                  s_axil_awready;
   logic [DATA_WIDTH-1:0] s_axil_wdata;
   logic [STRB_WIDTH-1:0] s_axil_wstrb;
   logic                  s_axil_wvalid;
   logic                  s_axil_wready;
   logic [1:0]            s_axil_bresp;
   logic                  s_axil_bvalid;
   logic                  s_axil_bready;
   logic [ADDR_WIDTH-1:0] s_axil_araddr;
   logic [2:0]            s_axil_arprot;
   logic                  s_axil_arvalid;
   logic                  s_axil_arready;
   logic [DATA_WIDTH-1:0] s_axil_rdata;
   logic [1:0]            s_axil_rresp;
   logic                  s_axil_rvalid;
   logic                  s_axil_rready;

   modport master (
      output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
      input  s_axil_awready,
      output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      input  s_axil_wready,
      input  s_axil_bresp, s_axil_bvalid,
      output s_axil_bready,
      output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
      input  s_axil_arready,
      input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      output s_axil_rready
   );

   modport slave (
      input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
      output s_axil_awready,
      input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      output s_axil_wready,
      output s_axil_bresp, s_axil_bvalid,
      input  s_axil_bready,
      input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
      output s_axil_arready,
      output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      input  s_axil_rready
   );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite register bank: REG_COUNT 32-bit registers with byte-strobed writes,
// independent AW/W acceptance, SLVERR for out-of-range indices, per-register write pulses.
module axil_reg_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int REG_COUNT  = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   axil_if.slave                            s_axil,
   output logic [REG_COUNT*DATA_WIDTH-1:0]  reg_out,
   output logic [REG_COUNT-1:0]             reg_wr_stb
);
   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];

   logic                  aw_held, w_held;
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [STRB_WIDTH-1:0] strb_q;

   logic                  aw_hs, w_hs, ar_hs, commit;
   logic                  aw_held_n, w_held_n, bvalid_n, rvalid_n;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] data_c, rd_value;
   logic [STRB_WIDTH-1:0] strb_c;
   logic                  wr_in_range, rd_in_range;
   logic                  unused_bits;

   assign unused_bits = ^{s_axil.s_axil_awprot, s_axil.s_axil_arprot,
                          s_axil.s_axil_awaddr[1:0], s_axil.s_axil_araddr[1:0]};

   assign aw_hs = s_axil.s_axil_awvalid & s_axil.s_axil_awready;
   assign w_hs  = s_axil.s_axil_wvalid  & s_axil.s_axil_wready;
   assign ar_hs = s_axil.s_axil_arvalid & s_axil.s_axil_arready;

   // A write commits as soon as both halves are present, whether held or arriving now.
   assign commit = (aw_held | aw_hs) & (w_held | w_hs);
   assign wr_idx = aw_held ? aw_idx_q : s_axil.s_axil_awaddr[ADDR_WIDTH-1:2];
   assign data_c = w_held ? data_q : s_axil.s_axil_wdata;
   assign strb_c = w_held ? strb_q : s_axil.s_axil_wstrb;
   assign rd_idx = s_axil.s_axil_araddr[ADDR_WIDTH-1:2];

   assign wr_in_range = 32'(wr_idx) < REG_COUNT;
   assign rd_in_range = 32'(rd_idx) < REG_COUNT;

   assign aw_held_n = (aw_held | aw_hs) & ~commit;
   assign w_held_n  = (w_held | w_hs) & ~commit;
   assign bvalid_n  = commit | (s_axil.s_axil_bvalid & ~s_axil.s_axil_bready);
   assign rvalid_n  = ar_hs | (s_axil.s_axil_rvalid & ~s_axil.s_axil_rready);

   always_comb begin
      rd_value = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (rd_idx == IDX_W'(i)) rd_value = regs[i];
      end
   end

   for (genvar g = 0; g < REG_COUNT; g++) begin : g_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held               <= 1'b0;
         w_held                <= 1'b0;
         aw_idx_q              <= '0;
         data_q                <= '0;
         strb_q                <= '0;
         reg_wr_stb            <= '0;
         s_axil.s_axil_awready <= 1'b0;
         s_axil.s_axil_wready  <= 1'b0;
         s_axil.s_axil_bvalid  <= 1'b0;
         s_axil.s_axil_bresp   <= RESP_OKAY;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         aw_held <= aw_held_n;
         w_held  <= w_held_n;
         if (aw_hs) aw_idx_q <= s_axil.s_axil_awaddr[ADDR_WIDTH-1:2];
         if (w_hs) begin
            data_q <= s_axil.s_axil_wdata;
            strb_q <= s_axil.s_axil_wstrb;
         end
         // Readies are registered from next-state so a held half blocks its channel immediately.
         s_axil.s_axil_awready <= ~aw_held_n & ~bvalid_n;
         s_axil.s_axil_wready  <= ~w_held_n & ~bvalid_n;
         s_axil.s_axil_bvalid  <= bvalid_n;
         if (commit) s_axil.s_axil_bresp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
         reg_wr_stb <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            if (commit && wr_in_range && wr_idx == IDX_W'(i)) begin
               if (|strb_c) reg_wr_stb[i] <= 1'b1;
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (strb_c[b]) regs[i][b*8 +: 8] <= data_c[b*8 +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_axil.s_axil_arready <= 1'b0;
         s_axil.s_axil_rvalid  <= 1'b0;
         s_axil.s_axil_rdata   <= '0;
         s_axil.s_axil_rresp   <= RESP_OKAY;
      end else begin
         s_axil.s_axil_arready <= ~rvalid_n;
         s_axil.s_axil_rvalid  <= rvalid_n;
         if (ar_hs) begin
            s_axil.s_axil_rdata <= rd_in_range ? rd_value : '0;
            s_axil.s_axil_rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end
endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: expected B/R responses and write pulses are queued
// at issue time and checked by a monitor whenever the DUT presents them.
module tb_axil_reg_bank;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SW = 4;
   localparam int RC = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();
   logic [RC*DW-1:0] reg_out;
   logic [RC-1:0]    reg_wr_stb;

   axil_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .REG_COUNT(RC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_axil     (bus),
      .reg_out    (reg_out),
      .reg_wr_stb (reg_wr_stb)
   );

   int total = 0;
   int bad = 0;
   logic [1:0]    exp_b_q[$];
   logic [33:0]   exp_r_q[$];
   logic [RC-1:0] exp_stb_q[$];
   logic [31:0]   model [RC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < RC; i++)
         chk($sformatf("%s_reg%0d", tag, i), 64'(reg_out[i*DW +: DW]), 64'(model[i]));
   endtask

   // Monitor: a response or pulse shown by the DUT must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.s_axil_bvalid && bus.s_axil_bready) begin
            if (exp_b_q.size() == 0) chk("b_unexpected", 64'(bus.s_axil_bvalid), 64'd0);
            else chk("bresp", 64'(bus.s_axil_bresp), 64'(exp_b_q.pop_front()));
         end
         if (bus.s_axil_rvalid && bus.s_axil_rready) begin
            if (exp_r_q.size() == 0) chk("r_unexpected", 64'(bus.s_axil_rvalid), 64'd0);
            else chk("rresp_rdata", 64'({bus.s_axil_rresp, bus.s_axil_rdata}), 64'(exp_r_q.pop_front()));
         end
         if (reg_wr_stb != '0) begin
            if (exp_stb_q.size() == 0) chk("stb_unexpected", 64'(reg_wr_stb), 64'd0);
            else chk("reg_wr_stb", 64'(reg_wr_stb), 64'(exp_stb_q.pop_front()));
         end
      end
   end

   task automatic send_aw(input logic [AW-1:0] addr);
      int n = 0;
      bus.s_axil_awaddr  = addr;
      bus.s_axil_awvalid = 1'b1;
      @(negedge clk);
      while (!bus.s_axil_awready && n < 50) begin @(negedge clk); n++; end
      if (!bus.s_axil_awready) chk("aw_timeout", 64'(bus.s_axil_awready), 64'd1);
      @(posedge clk); #1;
      bus.s_axil_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [DW-1:0] data, input logic [SW-1:0] strb);
      int n = 0;
      bus.s_axil_wdata  = data;
      bus.s_axil_wstrb  = strb;
      bus.s_axil_wvalid = 1'b1;
      @(negedge clk);
      while (!bus.s_axil_wready && n < 50) begin @(negedge clk); n++; end
      if (!bus.s_axil_wready) chk("w_timeout", 64'(bus.s_axil_wready), 64'd1);
      @(posedge clk); #1;
      bus.s_axil_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [AW-1:0] addr);
      int n = 0;
      bus.s_axil_araddr  = addr;
      bus.s_axil_arvalid = 1'b1;
      @(negedge clk);
      while (!bus.s_axil_arready && n < 50) begin @(negedge clk); n++; end
      if (!bus.s_axil_arready) chk("ar_timeout", 64'(bus.s_axil_arready), 64'd1);
      @(posedge clk); #1;
      bus.s_axil_arvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_axil_awaddr = '0; bus.s_axil_awprot = '0; bus.s_axil_awvalid = 1'b0;
      bus.s_axil_wdata = '0; bus.s_axil_wstrb = '0; bus.s_axil_wvalid = 1'b0;
      bus.s_axil_bready = 1'b1;
      bus.s_axil_araddr = '0; bus.s_axil_arprot = '0; bus.s_axil_arvalid = 1'b0;
      bus.s_axil_rready = 1'b1;
      for (int i = 0; i < RC; i++) model[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_awready", 64'(bus.s_axil_awready), 64'd0);
      chk("rst_wready", 64'(bus.s_axil_wready), 64'd0);
      chk("rst_arready", 64'(bus.s_axil_arready), 64'd0);
      chk("rst_bvalid", 64'(bus.s_axil_bvalid), 64'd0);
      chk("rst_rvalid", 64'(bus.s_axil_rvalid), 64'd0);
      chk("rst_rdata", 64'(bus.s_axil_rdata), 64'd0);
      chk("rst_stb", 64'(reg_wr_stb), 64'd0);
      check_regs("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("pre_edge_awready", 64'(bus.s_axil_awready), 64'd0);
      @(posedge clk); #1;
      chk("post_rst_awready", 64'(bus.s_axil_awready), 64'd1);
      chk("post_rst_wready", 64'(bus.s_axil_wready), 64'd1);
      chk("post_rst_arready", 64'(bus.s_axil_arready), 64'd1);

      // AW and W on the same edge
      exp_b_q.push_back(2'b00);
      exp_stb_q.push_back(16'h0004);
      fork
         send_aw(16'h0008);
         send_w(32'hDEADBEEF, 4'hF);
      join
      model[2] = 32'hDEADBEEF;
      chk("w1_reg2", 64'(reg_out[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
      chk("w1_stb_now", 64'(reg_wr_stb), 64'h0004);
      chk("w1_bvalid_now", 64'(bus.s_axil_bvalid), 64'd1);
      repeat (2) @(posedge clk); #1;
      chk("w1_awready_back", 64'(bus.s_axil_awready), 64'd1);

      // W three cycles ahead of AW, partial strobe
      exp_b_q.push_back(2'b00);
      exp_stb_q.push_back(16'h0004);
      send_w(32'h11223344, 4'h5);
      repeat (3) @(posedge clk); #1;
      chk("w2_reg2_before", 64'(reg_out[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
      chk("w2_wready_held", 64'(bus.s_axil_wready), 64'd0);
      chk("w2_bvalid_before", 64'(bus.s_axil_bvalid), 64'd0);
      send_aw(16'h0008);
      model[2] = 32'hDE22BE44;
      chk("w2_reg2_after", 64'(reg_out[2*DW +: DW]), 64'h0000_0000_DE22_BE44);
      repeat (2) @(posedge clk); #1;

      // Out of range write and read
      exp_b_q.push_back(2'b10);
      fork
         send_aw(16'h0040);
         send_w(32'hFFFFFFFF, 4'hF);
      join
      repeat (3) @(posedge clk); #1;
      check_regs("oor");
      exp_r_q.push_back({2'b10, 32'h0});
      send_ar(16'h0040);
      repeat (2) @(posedge clk); #1;

      // Read with rready held low for five cycles
      bus.s_axil_rready = 1'b0;
      exp_r_q.push_back({2'b00, 32'hDE22BE44});
      send_ar(16'h0008);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_rvalid", 64'(bus.s_axil_rvalid), 64'd1);
         chk("stall_rdata", 64'(bus.s_axil_rdata), 64'h0000_0000_DE22_BE44);
         chk("stall_arready", 64'(bus.s_axil_arready), 64'd0);
      end
      @(posedge clk); #1;
      bus.s_axil_rready = 1'b1;
      @(posedge clk); #1;
      chk("stall_arready_back", 64'(bus.s_axil_arready), 64'd1);
      chk("stall_rvalid_clear", 64'(bus.s_axil_rvalid), 64'd0);

      // Read and write commit of reg 3 on the same edge: read sees old value
      exp_b_q.push_back(2'b00);
      exp_stb_q.push_back(16'h0008);
      exp_r_q.push_back({2'b00, 32'h0});
      fork
         send_aw(16'h000C);
         send_w(32'h12345678, 4'hF);
         send_ar(16'h000C);
      join
      model[3] = 32'h12345678;
      repeat (2) @(posedge clk); #1;
      exp_r_q.push_back({2'b00, 32'h12345678});
      send_ar(16'h000C);
      repeat (2) @(posedge clk); #1;
      check_regs("mid");

      // Reset with AW held and W arriving
      send_aw(16'h0010);
      bus.s_axil_wdata  = 32'hCAFEF00D;
      bus.s_axil_wstrb  = 4'hF;
      bus.s_axil_wvalid = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_wready", 64'(bus.s_axil_wready), 64'd0);
      chk("rst2_bvalid", 64'(bus.s_axil_bvalid), 64'd0);
      for (int i = 0; i < RC; i++) model[i] = '0;
      check_regs("rst2");
      repeat (2) @(posedge clk); #1;
      bus.s_axil_wvalid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst2_awready", 64'(bus.s_axil_awready), 64'd1);
      chk("rst2_wready_up", 64'(bus.s_axil_wready), 64'd1);
      chk("rst2_arready", 64'(bus.s_axil_arready), 64'd1);
      repeat (4) @(negedge clk);
      chk("rst2_no_bvalid", 64'(bus.s_axil_bvalid), 64'd0);

      // The abandoned AW must not pair with a fresh W
      @(posedge clk); #1;
      send_w(32'hAAAA5555, 4'hF);
      repeat (3) @(posedge clk); #1;
      chk("rst2_w_alone_bvalid", 64'(bus.s_axil_bvalid), 64'd0);
      exp_b_q.push_back(2'b00);
      exp_stb_q.push_back(16'h0020);
      send_aw(16'h0014);
      model[5] = 32'hAAAA5555;
      repeat (2) @(posedge clk); #1;
      check_regs("end");

      begin
         int n = 0;
         while ((exp_b_q.size() != 0 || exp_r_q.size() != 0 || exp_stb_q.size() != 0) && n < 100) begin
            @(posedge clk); n++;
         end
      end
      chk("b_q_left", 64'(exp_b_q.size()), 64'd0);
      chk("r_q_left", 64'(exp_r_q.size()), 64'd0);
      chk("stb_q_left", 64'(exp_stb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
